// File: rtl/detect_pkg.sv
// Shared definitions for the time-multiplexed "01" sequence detector.
//   STATE_W       : width of one stored per-channel detector state
//   det_state_e   : detector state encoding
//   recover_state : maps any stored encoding onto a legal state
package detect_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'b00,
        S_ZERO = 2'b01
    } det_state_e;

    // Only S_ZERO is kept as-is; every other encoding, including the
    // unused ones, collapses to S_IDLE so a corrupted slot heals itself.
    function automatic det_state_e recover_state(input logic [STATE_W-1:0] s);
        return (s == S_ZERO) ? S_ZERO : S_IDLE;
    endfunction

endpackage

// File: rtl/detect_step.sv
// One combinational step of the overlapping "01" detector.
//   state_i      : current stored state of the channel being served
//   bit_i        : serial data bit accepted this cycle
//   next_state_o : state to write back to that channel
//   match_o      : high when this bit completes a "01"
module detect_step
    import detect_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic               bit_i,
    output logic [STATE_W-1:0] next_state_o,
    output logic               match_o
);

    always_comb begin
        next_state_o = S_IDLE;
        match_o      = 1'b0;
        case (recover_state(state_i))
            S_ZERO: begin
                if (bit_i) begin
                    next_state_o = S_IDLE;
                    match_o      = 1'b1;
                end else begin
                    next_state_o = S_ZERO;
                end
            end
            default: next_state_o = bit_i ? S_IDLE : S_ZERO;
        endcase
    end

endmodule

// File: rtl/detect_scheduler.sv
// Round-robin scheduler sharing one detect_step across NCH serial channels.
//   clk, rst           : clock, asynchronous active-low reset
//   enable             : 0 blocks every grant
//   req_valid/req_bit  : per-channel bit handshake and data
//   req_ready          : one-hot (or zero) combinational grant
//   chan_clr           : per-channel detector clear, applied at next edge
//   count_clr          : clears match_count, wins over a coincident match
//   match_valid/ch     : registered match pulse and its channel tag
//   match_count        : saturating number of matches seen
module detect_scheduler
    import detect_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CHW   = $clog2(NCH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH-1:0]   req_bit,
    output logic [NCH-1:0]   req_ready,
    input  logic [NCH-1:0]   chan_clr,
    input  logic             count_clr,
    output logic             match_valid,
    output logic [CHW-1:0]   match_ch,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [CHW:0]   NCH_X = (CHW+1)'(NCH);
    localparam logic [CHW-1:0] LAST  = CHW'(NCH-1);

    logic [NCH-1:0][STATE_W-1:0] state_q;
    logic [CHW-1:0]              rr_ptr_q;
    logic                        match_valid_q;
    logic [CHW-1:0]              match_ch_q;
    logic [CNT_W-1:0]            match_count_q;

    logic [CHW:0]         cand;
    logic                 gnt_found;
    logic [CHW-1:0]       gnt_idx;
    logic                 xfer;
    logic [NCH-1:0]       gnt_oh;
    logic [STATE_W-1:0]   step_next;
    logic                 step_match;
    logic                 match_d;

    // Scan from rr_ptr upward with wrap; first requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NCH; off++) begin
            cand = {1'b0, rr_ptr_q} + (CHW+1)'(off);
            if (cand >= NCH_X) cand = cand - NCH_X;
            if (!gnt_found && req_valid[cand[CHW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CHW-1:0];
            end
        end
    end

    // rst gates the grant so no handshake can complete while in reset.
    assign xfer      = rst & enable & gnt_found;
    assign gnt_oh    = xfer ? (NCH'(1) << gnt_idx) : '0;
    assign req_ready = gnt_oh;

    detect_step u_step (
        .state_i      (state_q[gnt_idx]),
        .bit_i        (req_bit[gnt_idx]),
        .next_state_o (step_next),
        .match_o      (step_match)
    );

    // A clear on the granted channel still consumes the bit but drops the match.
    assign match_d = xfer & step_match & ~chan_clr[gnt_idx];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)             state_q[i] <= S_IDLE;
            else if (chan_clr[i]) state_q[i] <= S_IDLE;
            else if (gnt_oh[i])   state_q[i] <= step_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
            match_count_q <= '0;
        end else begin
            if (xfer) rr_ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + CHW'(1);
            match_valid_q <= match_d;
            if (match_d) match_ch_q <= gnt_idx;
            if (count_clr)
                match_count_q <= '0;
            else if (match_d && match_count_q != '1)
                match_count_q <= match_count_q + CNT_W'(1);
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_detect_scheduler.sv
module tb_detect_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] req_valid, req_bit, req_ready, chan_clr;
    logic       count_clr;
    logic       match_valid;
    logic [1:0] match_ch;
    logic [3:0] match_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    detect_scheduler #(.NCH(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_bit     (req_bit),
        .req_ready   (req_ready),
        .chan_clr    (chan_clr),
        .count_clr   (count_clr),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_count (match_count)
    );

    typedef struct packed {
        logic       en;
        logic [3:0] valid;
        logic [3:0] bits;
        logic [3:0] clr;
        logic       cclr;
        logic [3:0] ready;
        logic       mv;
        logic [1:0] mch;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [3:0] valid, input logic [3:0] bits,
                       input logic [3:0] clr, input logic cclr, input logic [3:0] ready,
                       input logic mv, input logic [1:0] mch, input logic [3:0] cnt);
        vec_t v;
        v = '{en, valid, bits, clr, cclr, ready, mv, mch, cnt};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] valid, input logic [3:0] bits,
                         input logic [3:0] clr, input logic cclr);
        enable    = en;
        req_valid = valid;
        req_bit   = bits;
        chan_clr  = clr;
        count_clr = cclr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        #2;
        chk("reset_ready", req_ready, 0);
        chk("reset_mv", match_valid, 0);
        chk("reset_mch", match_ch, 0);
        chk("reset_cnt", match_count, 0);
        step();
        rst = 1'b1;

        // ch0 alone: 0,1,1,0,1 -> matches on 2nd and 5th bit
        add(1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0);
        add(1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1);
        add(1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 1);
        add(1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1);
        add(1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 2);
        // all requesting, rr_ptr now 1: grants 1,2,3,0(wrap),1
        add(1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0010, 0, 0, 2);
        add(1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0100, 0, 0, 2);
        add(1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b1000, 0, 0, 2);
        add(1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0, 2);
        add(1, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0010, 0, 0, 2);
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2);
        // interleave: ch1 0, ch2 1, ch1 1 -> one match on ch1, none on ch2
        add(1, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 2);
        add(1, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 0, 0, 2);
        add(1, 4'b0010, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 3);
        add(1, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 0, 1, 3);
        // chan_clr on the granted channel: bit consumed, no match, back to idle
        add(1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 1, 3);
        add(1, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0001, 0, 1, 3);
        add(1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 1, 3);
        // chan_clr on an idle-requesting channel
        add(1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 1, 3);
        add(1, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0000, 0, 1, 3);
        add(1, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 1, 3);
        // ch3 half-way, enable off 5 cycles, then finish the "01"
        add(1, 4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 0, 1, 3);
        for (int k = 0; k < 5; k++)
            add(0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1, 3);
        add(1, 4'b1000, 4'b1000, 4'b0000, 0, 4'b1000, 1, 3, 4);
        // count_clr coinciding with a match -> 0
        add(1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 3, 4);
        add(1, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0);

        foreach (vecs[n]) begin
            drive(vecs[n].en, vecs[n].valid, vecs[n].bits, vecs[n].clr, vecs[n].cclr);
            #1;
            chk($sformatf("v%0d_ready", n), req_ready, vecs[n].ready);
            step();
            chk($sformatf("v%0d_mv", n), match_valid, vecs[n].mv);
            chk($sformatf("v%0d_mch", n), match_ch, vecs[n].mch);
            chk($sformatf("v%0d_cnt", n), match_count, vecs[n].cnt);
        end

        // saturation of a 4-bit counter: 16 matches on ch0, stops at 15
        for (int k = 1; k <= 16; k++) begin
            drive(1, 4'b0001, 4'b0000, 4'b0000, 0);
            step();
            drive(1, 4'b0001, 4'b0001, 4'b0000, 0);
            step();
            chk($sformatf("sat%0d_mv", k), match_valid, 1);
            chk($sformatf("sat%0d_cnt", k), match_count, (k > 15) ? 15 : k);
        end

        // reset during an active grant with a match pulse on the outputs
        drive(1, 4'b0100, 4'b0000, 4'b0000, 0);   // ch2 -> S_ZERO
        step();
        drive(1, 4'b0010, 4'b0000, 4'b0000, 0);   // ch1 -> S_ZERO
        step();
        drive(1, 4'b0010, 4'b0010, 4'b0000, 0);   // ch1 match
        step();
        chk("pre_rst_mv", match_valid, 1);
        chk("pre_rst_mch", match_ch, 1);
        chk("pre_rst_cnt", match_count, 15);
        drive(1, 4'b0010, 4'b0000, 4'b0000, 0);
        #1;
        chk("pre_rst_ready", req_ready, 4'b0010);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_mv", match_valid, 0);
        chk("rst_mch", match_ch, 0);
        chk("rst_cnt", match_count, 0);
        step();
        chk("rst_no_pulse", match_valid, 0);
        rst = 1'b1;
        drive(1, 4'b1111, 4'b0000, 4'b0000, 0);
        #1;
        chk("post_rst_rr", req_ready, 4'b0001);
        drive(1, 4'b0100, 4'b0100, 4'b0000, 0);   // ch2 state was cleared: no match
        #1;
        chk("post_rst_ready", req_ready, 4'b0100);
        step();
        chk("post_rst_mv", match_valid, 0);
        chk("post_rst_cnt", match_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/detect_scheduler.md
Name: detect_scheduler

Overview:
- Shares one bit-serial "01" sequence-detector step across NCH independent input channels by time-multiplexing.
- Round-robin arbitration accepts at most one bit per cycle. Per-channel detector state is saved and restored, so each channel behaves as if it had a private detector.
- Sits between the serial input sources and the match-reporting logic. Emits a tagged match pulse and keeps a global match count.

Parameters:
- NCH, 4, number of input channels (2..16)
- CHW, $clog2(NCH), channel-index width (derived; do not override)
- CNT_W, 16, width of the saturating match counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  grant enable; 0 = no channel is accepted
- req_valid  input  NCH  per-channel bit-valid
- req_bit  input  NCH  per-channel serial data bit
- req_ready  output  NCH  one-hot grant; a bit transfers on req_valid[i] & req_ready[i]
- chan_clr  input  NCH  synchronous per-channel detector clear
- count_clr  input  1  synchronous clear of match_count
- match_valid  output  1  one-cycle pulse: a match was detected
- match_ch  output  CHW  channel index of the match
- match_count  output  CNT_W  saturating total of matches

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - all channel states to S_IDLE
  - rr_ptr=0
  - match_valid=0, match_ch=0, match_count=0
- req_ready is combinational and is all-zero while rst=0.
- Per-channel detector, 2-bit state, overlapping "01" detection:
  - S_IDLE, bit 0 -> S_ZERO
  - S_IDLE, bit 1 -> S_IDLE
  - S_ZERO, bit 0 -> S_ZERO
  - S_ZERO, bit 1 -> S_IDLE, and a match is flagged
  - Encoding 2'b11 is illegal and must recover to S_IDLE.
- Arbitration:
  - Grant goes to the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap modulo NCH.
  - req_ready is one-hot or zero, and zero when enable=0.
  - Combinational dependence of req_ready on req_valid is permitted.
  - On a transfer from channel g: rr_ptr <= (g+1) mod NCH. With no transfer, rr_ptr holds.
  - A channel that keeps requesting is served at least once every NCH cycles.
- Datapath:
  - The granted channel's stored state and its req_bit go through detect_step. The next state is written back to that channel only.
  - Non-granted channel states hold.
- Match output:
  - Registered, latency 1. match_valid=1 and match_ch=g in the cycle after the accepting edge.
  - match_valid=0 otherwise; match_ch holds its last value.
- match_count:
  - Increments on each match, saturating at 2^CNT_W-1 with no wrap.
  - count_clr forces it to 0. If count_clr coincides with a match, the result is 0 (clear wins).
- chan_clr[i]:
  - Sets channel i to S_IDLE at the next edge.
  - It does not block the grant. If channel i is granted in the same cycle, the bit is consumed (handshake completes), its state update is discarded, and no match is flagged.
- enable deasserted mid-stream: no transfers occur, states and rr_ptr hold, and nothing is lost. Streams resume exactly where they stopped.
- Bits held with req_valid=1 and req_ready=0 must remain stable; the block does not sample them.
- Reset mid-operation: everything returns to reset values immediately. In-flight match pulses are dropped.

Decomposition:
- Shared package detect_pkg holds:
  - the state typedef (S_IDLE=2'b00, S_ZERO=2'b01)
  - the illegal-state recovery rule
  - the 2-bit state width constant
- Sub-module detect_step: purely combinational. Inputs state and bit; outputs next_state and match.
- The round-robin arbiter stays inline in detect_scheduler.

Test Plan:
- Reset released, channel 0 only, bits 0,1,1,0,1 -> match_valid pulses the cycle after the 2nd and 5th accepts. match_ch=0, match_count=2.
- All 4 channels requesting every cycle, enable=1 -> grants cycle 0,1,2,3,0,...; rr_ptr wraps 3->0; each req_ready is one-hot.
- Interleaving check:
  - Ch1 sends 0, then ch2 sends 1, then ch1 sends 1 -> exactly one match with match_ch=1.
  - No false match on ch2 from ch1's saved state.
- chan_clr[0] in the same cycle that ch0 is granted with bit 1 while in S_ZERO -> handshake completes, no match, ch0 returns to S_IDLE.
- Saturation:
  - Preload via 2^16-1 matches (or CNT_W=4 build, 15 matches), then one more match -> count stays at max.
  - count_clr together with a match -> count=0.
- enable=0 for 5 cycles mid-stream, then asynchronous rst pulse during an active grant -> no transfers while enable=0. On rst, all outputs go to 0 immediately and no match pulse follows.
